// File: rtl/store_buffer.sv
// Posted-store buffer: alignment check, byte-lane placement and a DEPTH-entry FIFO
// drained to the data-memory port through req/gnt, with load-overlap detection.
module store_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enq_valid_i,
  output logic                enq_ready_o,
  input  logic [1:0]          enq_size_i,
  input  logic [XLEN-1:0]     enq_addr_i,
  input  logic [XLEN-1:0]     enq_data_i,
  output logic                misalign_o,
  output logic                mem_req_o,
  input  logic                mem_gnt_i,
  output logic [XLEN-1:0]     mem_addr_o,
  output logic [XLEN-1:0]     mem_wdata_o,
  output logic [XLEN/8-1:0]   mem_be_o,
  input  logic [XLEN-1:0]     ld_addr_i,
  output logic                ld_hazard_o,
  output logic                empty_o
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             misalign_q, misalign_d;

  logic [XLEN-1:0]  addr_mem  [DEPTH];
  logic [XLEN-1:0]  wdata_mem [DEPTH];
  logic [NB-1:0]    be_mem    [DEPTH];

  logic             fire, legal, push, pop;
  logic [2:0]       align_mask;
  logic [7:0]       size_be;
  logic [OFFW-1:0]  off;
  logic [NB-1:0]    be_enc;
  logic [XLEN-1:0]  data_shift, wdata_enc, addr_enc, ld_word;
  logic [DEPTH-1:0] hit;

  assign enq_ready_o = (count_q != CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign mem_req_o   = !empty_o;
  assign misalign_o  = misalign_q;
  assign fire        = enq_valid_i && enq_ready_o;
  assign pop         = mem_req_o && mem_gnt_i;

  always_comb begin
    align_mask = 3'b000;
    size_be    = 8'h01;
    case (enq_size_i)
      2'd0:    begin align_mask = 3'b000; size_be = 8'h01; end
      2'd1:    begin align_mask = 3'b001; size_be = 8'h03; end
      2'd2:    begin align_mask = 3'b011; size_be = 8'h0F; end
      default: begin align_mask = 3'b111; size_be = 8'hFF; end
    endcase
  end

  // Double-word stores only exist on a 64-bit datapath.
  assign legal      = ((enq_size_i != 2'd3) || (XLEN == 64)) && !(|(enq_addr_i[2:0] & align_mask));
  assign push       = fire && legal;
  assign off        = enq_addr_i[OFFW-1:0];
  assign be_enc     = NB'(size_be) << off;
  assign data_shift = enq_data_i << {off, 3'b000};
  assign addr_enc   = {enq_addr_i[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign ld_word    = {ld_addr_i[XLEN-1:OFFW], {OFFW{1'b0}}};

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign wdata_enc[8*gi +: 8] = be_enc[gi] ? data_shift[8*gi +: 8] : 8'h00;
    end
    for (gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign hit[gi] = valid_q[gi] && (addr_mem[gi] == ld_word);
    end
  endgenerate

  assign ld_hazard_o = |hit;

  // Head outputs are forced to zero when nothing is pending so stale slots never leak.
  assign mem_addr_o  = mem_req_o ? addr_mem[rd_ptr_q]  : '0;
  assign mem_wdata_o = mem_req_o ? wdata_mem[rd_ptr_q] : '0;
  assign mem_be_o    = mem_req_o ? be_mem[rd_ptr_q]    : '0;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    misalign_d = fire && !legal;
    valid_d    = valid_q;
    if (pop)  valid_d[rd_ptr_q] = 1'b0;
    if (push) valid_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q]  <= addr_enc;
      wdata_mem[wr_ptr_q] <= wdata_enc;
      be_mem[wr_ptr_q]    <= be_enc;
    end
  end

endmodule
